// File: rtl/pipeline_regfile_wb.sv
// W-stage writeback: result select, 32-entry integer register file, two async read ports and a retired-write counter.
// Optional build macro REGFILE_BYPASS_EN enables write-through bypass on the read ports.
`ifndef XLEN
`define XLEN 32
`endif

module pipeline_regfile_wb #(
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_ctrl_reg_wr_enW,
  input  logic [1:0]        i_ctrl_result_srcW,
  input  logic [`XLEN-1:0]  i_alu_resultW,
  input  logic [`XLEN-1:0]  i_mem_readdataW,
  input  logic [`XLEN-1:0]  i_PCPlus4W,
  input  logic [4:0]        i_regfile_rd_addrW,
  input  logic [4:0]        i_regfile_rs1_addrD,
  input  logic [4:0]        i_regfile_rs2_addrD,
  output logic [`XLEN-1:0]  o_regfile_rs1_dataD,
  output logic [`XLEN-1:0]  o_regfile_rs2_dataD,
  output logic [`XLEN-1:0]  o_resultW,
  output logic [CNT_W-1:0]  o_wb_count
);

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_MEM  = 2'b01,
    SRC_PC4  = 2'b10,
    SRC_RSVD = 2'b11
  } result_src_e;

  logic [`XLEN-1:0] regs_q [NREG];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [`XLEN-1:0] result_d;
  logic             wr_commit;

  // NOTE: every branch of a combinational block must assign its outputs; the default-first pattern below prevents latch inference.
  always_comb begin
    result_d = i_alu_resultW;
    unique case (result_src_e'(i_ctrl_result_srcW))
      SRC_MEM:  result_d = i_mem_readdataW;
      SRC_PC4:  result_d = i_PCPlus4W;
      default:  result_d = i_alu_resultW;
    endcase
  end

  assign o_resultW = result_d;
  assign wr_commit = i_ctrl_reg_wr_enW && (i_regfile_rd_addrW != 5'd0);
  assign cnt_d     = wr_commit ? cnt_q + CNT_W'(1) : cnt_q;

  // NOTE: the register array is architectural state that must read as zero out of reset, so it is reset like any other flop rather than left uninitialised as a RAM would be.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_commit) begin
      // NOTE: non-blocking assignment keeps the update visible only after the edge, so the read ports see old data this cycle.
      regs_q[i_regfile_rd_addrW] <= result_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_wb_count = cnt_q;

  // Entry 0 is never written, but the explicit zero keeps x0 reads independent of the array contents.
  always_comb begin
    o_regfile_rs1_dataD = '0;
    o_regfile_rs2_dataD = '0;
    if (i_regfile_rs1_addrD != 5'd0) o_regfile_rs1_dataD = regs_q[i_regfile_rs1_addrD];
    if (i_regfile_rs2_addrD != 5'd0) o_regfile_rs2_dataD = regs_q[i_regfile_rs2_addrD];
`ifdef REGFILE_BYPASS_EN
    if (i_rstn && wr_commit && (i_regfile_rs1_addrD == i_regfile_rd_addrW)) o_regfile_rs1_dataD = result_d;
    if (i_rstn && wr_commit && (i_regfile_rs2_addrD == i_regfile_rd_addrW)) o_regfile_rs2_dataD = result_d;
`endif
  end

endmodule

// File: tb/tb_pipeline_regfile_wb.sv
// Scoreboard bench for pipeline_regfile_wb: a driver pushes model predictions, a negedge monitor pops and compares.
`ifndef XLEN
`define XLEN 32
`endif

module tb_pipeline_regfile_wb;

  logic              i_clk = 1'b0;
  logic              i_rstn;
  logic              wen;
  logic [1:0]        src;
  logic [`XLEN-1:0]  alu, mem, pc4;
  logic [4:0]        rd, a1, a2;
  logic [`XLEN-1:0]  rs1, rs2, res;
  logic [31:0]       cnt;
  logic [`XLEN-1:0]  rs1_4, rs2_4, res_4;
  logic [3:0]        cnt4;

  always #5 i_clk = ~i_clk;

  pipeline_regfile_wb dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_ctrl_reg_wr_enW(wen), .i_ctrl_result_srcW(src),
    .i_alu_resultW(alu), .i_mem_readdataW(mem), .i_PCPlus4W(pc4),
    .i_regfile_rd_addrW(rd), .i_regfile_rs1_addrD(a1), .i_regfile_rs2_addrD(a2),
    .o_regfile_rs1_dataD(rs1), .o_regfile_rs2_dataD(rs2), .o_resultW(res), .o_wb_count(cnt)
  );

  pipeline_regfile_wb #(.CNT_W(4)) dut4 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_ctrl_reg_wr_enW(wen), .i_ctrl_result_srcW(src),
    .i_alu_resultW(alu), .i_mem_readdataW(mem), .i_PCPlus4W(pc4),
    .i_regfile_rd_addrW(rd), .i_regfile_rs1_addrD(a1), .i_regfile_rs2_addrD(a2),
    .o_regfile_rs1_dataD(rs1_4), .o_regfile_rs2_dataD(rs2_4), .o_resultW(res_4), .o_wb_count(cnt4)
  );

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] res;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl [32];
  int unsigned mdl_cnt;
  bit          obs_valid = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mdl_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : mdl[a];
  endfunction

  // Monitor: compares whatever the DUT presents mid-cycle against the oldest prediction.
  always @(negedge i_clk) begin
    if (obs_valid) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: DUT output observed with no prediction queued at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.tag, "/rs1"},   rs1, e.rs1);
        check({e.tag, "/rs2"},   rs2, e.rs2);
        check({e.tag, "/res"},   res, e.res);
        check({e.tag, "/cnt"},   cnt, e.cnt);
        check({e.tag, "/cnt4"},  {28'd0, cnt4}, {28'd0, e.cnt4});
        check({e.tag, "/rs1_4"}, rs1_4, e.rs1);
      end
    end
  end

  // Drive one W-stage transaction at posedge+1, predict its observable effects, then advance one cycle.
  task automatic step(input bit w, input logic [1:0] s, input logic [31:0] va, vm, vp,
                      input logic [4:0] d, r1, r2, input string tag);
    exp_t        e;
    logic [31:0] sel;
    wen = w; src = s; alu = va; mem = vm; pc4 = vp; rd = d; a1 = r1; a2 = r2;
    if (!i_rstn) begin
      foreach (mdl[i]) mdl[i] = '0;
      mdl_cnt = 0;
    end
    sel = (s == 2'd1) ? vm : (s == 2'd2) ? vp : va;
    e.res  = sel;
    e.rs1  = mdl_rd(r1);
    e.rs2  = mdl_rd(r2);
`ifdef REGFILE_BYPASS_EN
    if (i_rstn && w && d != 5'd0) begin
      if (r1 == d) e.rs1 = sel;
      if (r2 == d) e.rs2 = sel;
    end
`endif
    e.cnt  = mdl_cnt;
    e.cnt4 = 4'(mdl_cnt % 16);
    e.tag  = tag;
    exp_q.push_back(e);
    obs_valid = 1'b1;
    @(posedge i_clk);
    if (i_rstn && w && d != 5'd0) begin
      mdl[d] = sel;
      mdl_cnt++;
    end
    #1;
  endtask

  initial begin
    i_rstn = 1'b0;
    wen = 0; src = 0; alu = 0; mem = 0; pc4 = 0; rd = 0; a1 = 0; a2 = 0;
    foreach (mdl[i]) mdl[i] = '0;
    mdl_cnt = 0;
    @(posedge i_clk); #1;

    step(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd31, "reset_init");
    i_rstn = 1'b1;

    // Mid-run reset clears x5 and the counter at once; the pending write to x6 is lost.
    step(1'b1, 2'd0, 32'h12345678, 32'h0, 32'h0, 5'd5, 5'd5, 5'd0, "wr_x5");
    step(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5, "rd_x5");
    i_rstn = 1'b0;
    step(1'b1, 2'd0, 32'h55, 32'h0, 32'h0, 5'd6, 5'd5, 5'd6, "midrun_reset");
    i_rstn = 1'b1;
    step(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd6, "after_reset");

    for (int s = 0; s < 4; s++)
      step(1'b1, 2'(s), 32'hA, 32'hB, 32'hC, 5'd3, 5'd3, 5'd3, $sformatf("mux_src%0d", s));
    step(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3, "mux_final");

    step(1'b1, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, "x0_write");
    step(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, "x0_read");

    step(1'b1, 2'd0, 32'h11, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7, "wr_x7");
    step(1'b0, 2'd0, 32'hFF, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7, "wen_low");
    step(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0, "x7_keep");

    step(1'b1, 2'd0, 32'h1, 32'h0, 32'h0, 5'd9, 5'd0, 5'd0, "wr_x9");
    step(1'b1, 2'd0, 32'h2, 32'h0, 32'h0, 5'd9, 5'd9, 5'd9, "rdw_x9");
    step(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9, "rdw_after");

    // Seventeen commits from reset wrap the 4-bit counter to 1.
    i_rstn = 1'b0;
    step(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, "wrap_reset");
    i_rstn = 1'b1;
    for (int k = 0; k < 17; k++)
      step(1'b1, 2'd2, 32'h0, 32'h0, 32'(k * 4), 5'(1 + k % 31), 5'(k % 32), 5'd1, "wrap_wr");
    check("cnt4_wrap", {28'd0, cnt4}, 32'd1);
    check("cnt_17", cnt, 32'd17);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] d, r1, r2;
      d  = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
           d, r1, r2, "rand");
    end

    obs_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_regfile_wb.md
Name: pipeline_regfile_wb

Overview:
- Consumer end of the MEM/WB pipeline interface: takes the W-stage control and data signals and commits results into the architectural integer register file.
- Selects the writeback result and writes it into a 32 x `XLEN register file.
- Provides two combinational read ports to the decode stage.
- Exposes the selected W result for the forwarding path, plus a retired-write counter for debug.

Parameters:
- NREG, 32, number of architectural registers; the address width is fixed at 5 bits.
- CNT_W, 32, width of the retired-write counter.

Ports:
- i_clk  input  1  clock, all state updates on posedge.
- i_rstn  input  1  asynchronous active-low reset.
- i_ctrl_reg_wr_enW  input  1  register write enable from the W stage.
- i_ctrl_result_srcW  input  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 reserved.
- i_alu_resultW  input  `XLEN  ALU result.
- i_mem_readdataW  input  `XLEN  load data.
- i_PCPlus4W  input  `XLEN  link value.
- i_regfile_rd_addrW  input  5  destination register.
- i_regfile_rs1_addrD  input  5  read port 1 address.
- i_regfile_rs2_addrD  input  5  read port 2 address.
- o_regfile_rs1_dataD  output  `XLEN  read port 1 data.
- o_regfile_rs2_dataD  output  `XLEN  read port 2 data.
- o_resultW  output  `XLEN  selected writeback value, for forwarding.
- o_wb_count  output  CNT_W  number of committed register writes.

Behaviour:
- Clocking and reset: one clock, i_clk; reset i_rstn is asynchronous, active-low.
- Reset state: while i_rstn=0, all registers x1..x31 are 0 and o_wb_count=0.
- Reset release: the first write can occur on the first posedge after deassertion.
- Result mux (combinational):
  - 00 -> i_alu_resultW.
  - 01 -> i_mem_readdataW.
  - 10 -> i_PCPlus4W.
  - 11 -> i_alu_resultW (reserved encoding, defined so it never produces X).
  - o_resultW always reflects the current inputs, whether or not a write is enabled.
- Write port: on posedge, if i_ctrl_reg_wr_enW=1 and i_regfile_rd_addrW!=0, reg[rd] <= o_resultW. Latency 1 cycle.
- x0: writes to x0 are discarded and do not count. Reads of address 0 return 0 under all conditions.
- Read ports: asynchronous. Each returns reg[addr], which is 0 for address 0.
- Both read ports may address the same register at once, and each returns identical data.
- Read-during-write (same register, same cycle): behaviour depends on REGFILE_BYPASS_EN; see Optional Feature.
- Counter: o_wb_count increments by 1 on every posedge where a write actually commits (wr_en=1 and rd!=0).
  - It wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-operation: asserting i_rstn clears all state immediately, with no clock needed.
  - A write pending in the same cycle is lost.
- Unknown or X inputs when wr_en=0 must not change state.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass. If wr_en=1, rd!=0 and a read address equals rd in the same cycle, that read port returns o_resultW (the new value) combinationally. This removes the need for a separate W->D forwarding path.
- Not defined: read ports return the stored (old) value until the posedge commit. Hazard logic must stall or forward externally.
- x0 reads return 0 in both builds.

Test Plan:
- Reset check: assert i_rstn=0 mid-run after writing x5=0x12345678 -> rs1 read of x5 returns 0 immediately, and o_wb_count=0.
- Result mux: src=00/01/10/11 with alu=0xA, mem=0xB, pc4=0xC, rd=x3 -> x3 reads 0xA, 0xB, 0xC, 0xA on successive cycles, and o_wb_count advances by 4.
- x0 write: wr_en=1, rd=0, alu=0xDEADBEEF -> rs1/rs2 of x0 read 0, and o_wb_count is unchanged.
- Write enable low: wr_en=0, rd=x7, alu=0xFF -> x7 keeps its prior value 0x11, and the counter is unchanged.
- Read-during-write: x9=0x1, then write 0x2 to x9 with rs1=rs2=x9 in the same cycle -> reads 0x2 in the same cycle with REGFILE_BYPASS_EN defined, 0x1 without it; both builds read 0x2 after the posedge.
- Counter wrap: build with CNT_W=4 and commit 17 writes -> o_wb_count=1.
